regfile_multiport: RTL and testbench

//  Parametrised general-purpose register file for the pipelined MIPS core.

---
 rtl/regfile_multiport.sv | 99 +++++++++
 tb/tb_regfile_multiport.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_multiport.sv
// Multi-port register file: two rising-edge write ports, NUM_RD combinational read
// ports with optional same-cycle bypass, and a per-register pending-load scoreboard.
module regfile_multiport #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr0_en,
    input  logic [ADDR_W-1:0]        wr0_addr,
    input  logic [DATA_W-1:0]        wr0_data,
    input  logic                     wr1_en,
    input  logic [ADDR_W-1:0]        wr1_addr,
    input  logic [DATA_W-1:0]        wr1_data,
    input  logic                     busy_set,
    input  logic [ADDR_W-1:0]        busy_addr,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [ADDR_W-1:0]        dbg_addr,
    output logic [DATA_W-1:0]        dbg_data
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam bit ZR    = (ZERO_REG != 0);
    localparam bit BP    = (BYPASS != 0);

    if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
        $error("regfile_multiport: NUM_RD must be in 1..4");
    end

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_next;
    logic              wr0_ok;
    logic              wr1_ok;

    assign wr0_ok = wr0_en && !(ZR && wr0_addr == '0);
    assign wr1_ok = wr1_en && !(ZR && wr1_addr == '0);

    // wr1 is applied first so wr0 wins an address collision.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wr1_ok) regs[wr1_addr] <= wr1_data;
            if (wr0_ok) regs[wr0_addr] <= wr0_data;
        end
    end

    // A new load issued to the register being written back keeps it pending.
    always_comb begin
        busy_next = busy;
        if (wr1_en) busy_next[wr1_addr] = 1'b0;
        if (busy_set) busy_next[busy_addr] = 1'b1;
        if (ZR) busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic              b;

        assign a = rd_addr[k*ADDR_W +: ADDR_W];

        always_comb begin
            d = regs[a];
            if (BP && wr1_en && wr1_addr == a) d = wr1_data;
            if (BP && wr0_en && wr0_addr == a) d = wr0_data;
            if (ZR && a == '0) d = '0;
            if (!reset) d = '0;
        end

        always_comb begin
            b = busy[a];
            if (BP && wr1_en && wr1_addr == a) b = 1'b0;
            if (ZR && a == '0) b = 1'b0;
        end

        assign rd_data[k*DATA_W +: DATA_W] = d;
        assign rd_busy[k]                  = b;
    end

    assign dbg_data = regs[dbg_addr];

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench for regfile_multiport: a vector table on the default instance plus
// hand sequences for reset, collision and a ZERO_REG=0 / BYPASS=0 instance.
module tb_regfile_multiport;

    logic        clk;
    logic        reset;

    logic        wr0_en, wr1_en, busy_set;
    logic [4:0]  wr0_addr, wr1_addr, busy_addr, dbg_addr;
    logic [31:0] wr0_data, wr1_data;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic [31:0] dbg_data;

    logic        n_wr0_en, n_wr1_en, n_busy_set;
    logic [4:0]  n_wr0_addr, n_wr1_addr, n_busy_addr, n_dbg_addr;
    logic [31:0] n_wr0_data, n_wr1_data;
    logic [9:0]  n_rd_addr;
    logic [63:0] n_rd_data;
    logic [1:0]  n_rd_busy;
    logic [31:0] n_dbg_data;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    regfile_multiport u_dut (
        .clk(clk), .reset(reset),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .busy_set(busy_set), .busy_addr(busy_addr),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    regfile_multiport #(.ZERO_REG(0), .BYPASS(0)) u_nz (
        .clk(clk), .reset(reset),
        .wr0_en(n_wr0_en), .wr0_addr(n_wr0_addr), .wr0_data(n_wr0_data),
        .wr1_en(n_wr1_en), .wr1_addr(n_wr1_addr), .wr1_data(n_wr1_data),
        .busy_set(n_busy_set), .busy_addr(n_busy_addr),
        .rd_addr(n_rd_addr), .rd_data(n_rd_data), .rd_busy(n_rd_busy),
        .dbg_addr(n_dbg_addr), .dbg_data(n_dbg_data)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        w0e; logic [4:0] w0a; logic [31:0] w0d;
        logic        w1e; logic [4:0] w1a; logic [31:0] w1d;
        logic        bs;  logic [4:0] ba;
        logic [4:0]  ra0; logic [4:0] ra1; logic [4:0] da;
        logic [31:0] e_d0; logic e_b0; logic [31:0] e_d1; logic e_b1; logic [31:0] e_dbg;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs[NV];

    function automatic vec_t mk(logic w0e, logic [4:0] w0a, logic [31:0] w0d,
                                logic w1e, logic [4:0] w1a, logic [31:0] w1d,
                                logic bs, logic [4:0] ba,
                                logic [4:0] ra0, logic [4:0] ra1, logic [4:0] da,
                                logic [31:0] e_d0, logic e_b0,
                                logic [31:0] e_d1, logic e_b1, logic [31:0] e_dbg);
        vec_t v;
        v.w0e = w0e; v.w0a = w0a; v.w0d = w0d;
        v.w1e = w1e; v.w1a = w1a; v.w1d = w1d;
        v.bs = bs; v.ba = ba; v.ra0 = ra0; v.ra1 = ra1; v.da = da;
        v.e_d0 = e_d0; v.e_b0 = e_b0; v.e_d1 = e_d1; v.e_b1 = e_b1; v.e_dbg = e_dbg;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // scoreboard: expected value comes off the queue in the order it was pushed
    task automatic check_q(input string name, input logic [31:0] act);
        logic [31:0] exp;
        if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL %s: expected queue empty, got 0x%08h", name, act);
        end else begin
            exp = exp_q.pop_front();
            check(name, act, exp);
        end
    endtask

    // drivers
    task automatic idle_all();
        wr0_en = 0; wr0_addr = 0; wr0_data = 0;
        wr1_en = 0; wr1_addr = 0; wr1_data = 0;
        busy_set = 0; busy_addr = 0; rd_addr = 0; dbg_addr = 0;
        n_wr0_en = 0; n_wr0_addr = 0; n_wr0_data = 0;
        n_wr1_en = 0; n_wr1_addr = 0; n_wr1_data = 0;
        n_busy_set = 0; n_busy_addr = 0; n_rd_addr = 0; n_dbg_addr = 0;
    endtask

    task automatic drive_vec(input vec_t v);
        wr0_en = v.w0e; wr0_addr = v.w0a; wr0_data = v.w0d;
        wr1_en = v.w1e; wr1_addr = v.w1a; wr1_data = v.w1d;
        busy_set = v.bs; busy_addr = v.ba;
        rd_addr = {v.ra1, v.ra0}; dbg_addr = v.da;
    endtask

    initial begin
        idle_all();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // reset state: every address, both ports, both instances
        for (int a = 0; a < 32; a++) begin
            @(negedge clk);
            rd_addr = {5'(31 - a), 5'(a)};
            n_rd_addr = {5'(31 - a), 5'(a)};
            dbg_addr = 5'(a);
            #2;
            if (rd_data != 64'd0 || rd_busy != 2'b00 || dbg_data != 32'd0 ||
                n_rd_data != 64'd0 || n_rd_busy != 2'b00) begin
                total++; bad++;
                $display("FAIL reset_read a=%0d: data=0x%016h busy=%b dbg=0x%08h nz=0x%016h",
                         a, rd_data, rd_busy, dbg_data, n_rd_data);
            end else begin
                total++;
            end
        end
        idle_all();

        //           w0e w0a  w0d           w1e w1a  w1d        bs ba   ra0  ra1  da    e_d0          b0  e_d1          b1  e_dbg
        vecs[0]  = mk(0, 0,  0,            0, 0,  0,          0, 0,   5,   7,   5,    0,            0,  0,            0,  0);
        vecs[1]  = mk(1, 5,  32'hDEADBEEF, 0, 0,  0,          0, 0,   5,   6,   5,    32'hDEADBEEF, 0,  0,            0,  0);
        vecs[2]  = mk(0, 0,  0,            0, 0,  0,          0, 0,   6,   5,   5,    0,            0,  32'hDEADBEEF, 0,  32'hDEADBEEF);
        vecs[3]  = mk(0, 0,  0,            0, 0,  0,          1, 7,   7,   5,   7,    0,            0,  32'hDEADBEEF, 0,  0);
        vecs[4]  = mk(0, 0,  0,            0, 0,  0,          0, 0,   7,   7,   7,    0,            1,  0,            1,  0);
        vecs[5]  = mk(1, 7,  32'h11,       1, 7,  32'h22,     0, 0,   7,   7,   7,    32'h11,       0,  32'h11,       0,  0);
        vecs[6]  = mk(0, 0,  0,            0, 0,  0,          0, 0,   7,   7,   7,    32'h11,       0,  32'h11,       0,  32'h11);
        vecs[7]  = mk(0, 0,  0,            0, 0,  0,          1, 9,   9,   7,   9,    0,            0,  32'h11,       0,  0);
        vecs[8]  = mk(0, 0,  0,            0, 0,  0,          0, 0,   9,   9,   9,    0,            1,  0,            1,  0);
        vecs[9]  = mk(0, 0,  0,            0, 0,  0,          0, 0,   9,   9,   9,    0,            1,  0,            1,  0);
        vecs[10] = mk(0, 0,  0,            0, 0,  0,          0, 0,   9,   9,   9,    0,            1,  0,            1,  0);
        vecs[11] = mk(0, 0,  0,            1, 9,  32'h55,     0, 0,   9,   9,   9,    32'h55,       0,  32'h55,       0,  0);
        vecs[12] = mk(0, 0,  0,            1, 9,  32'h66,     1, 9,   9,   9,   9,    32'h66,       0,  32'h66,       0,  32'h55);
        vecs[13] = mk(0, 0,  0,            0, 0,  0,          0, 0,   9,   9,   9,    32'h66,       1,  32'h66,       1,  32'h66);
        vecs[14] = mk(1, 0,  32'hFFFFFFFF, 0, 0,  0,          1, 0,   0,   0,   0,    0,            0,  0,            0,  0);
        vecs[15] = mk(0, 0,  0,            0, 0,  0,          0, 0,   0,   0,   0,    0,            0,  0,            0,  0);
        vecs[16] = mk(1, 4,  32'hBBBB,     1, 3,  32'hAAAA,   0, 0,   3,   4,   3,    32'hAAAA,     0,  32'hBBBB,     0,  0);
        vecs[17] = mk(0, 0,  0,            0, 0,  0,          0, 0,   4,   3,   3,    32'hBBBB,     0,  32'hAAAA,     0,  32'hAAAA);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive_vec(vecs[i]);
            exp_q.push_back(vecs[i].e_d0);
            exp_q.push_back(32'(vecs[i].e_b0));
            exp_q.push_back(vecs[i].e_d1);
            exp_q.push_back(32'(vecs[i].e_b1));
            exp_q.push_back(vecs[i].e_dbg);
            #2;
            check_q($sformatf("v%0d_rd0_data", i), rd_data[31:0]);
            check_q($sformatf("v%0d_rd0_busy", i), 32'(rd_busy[0]));
            check_q($sformatf("v%0d_rd1_data", i), rd_data[63:32]);
            check_q($sformatf("v%0d_rd1_busy", i), 32'(rd_busy[1]));
            check_q($sformatf("v%0d_dbg", i), dbg_data);
        end
        idle_all();

        // ZERO_REG=0, BYPASS=0: r0 is ordinary, reads see writes one cycle later
        @(negedge clk);
        n_wr0_en = 1; n_wr0_addr = 0; n_wr0_data = 32'hFFFFFFFF;
        n_busy_set = 1; n_busy_addr = 0; n_rd_addr = 10'd0;
        #2;
        check("nz_r0_same_cycle", n_rd_data[31:0], 32'h0);
        check("nz_r0_busy_same_cycle", 32'(n_rd_busy[0]), 32'h0);
        @(negedge clk);
        n_wr0_en = 0; n_busy_set = 0;
        n_wr1_en = 1; n_wr1_addr = 0; n_wr1_data = 32'h1;
        #2;
        check("nz_r0_data", n_rd_data[31:0], 32'hFFFFFFFF);
        check("nz_r0_busy_no_bypass_clear", 32'(n_rd_busy[1]), 32'h1);
        @(negedge clk);
        n_wr1_en = 0;
        #2;
        check("nz_r0_data_after_wr1", n_rd_data[63:32], 32'h1);
        check("nz_r0_busy_cleared", 32'(n_rd_busy[0]), 32'h0);

        // mid-cycle reset wipes stored state and drops the write in flight
        @(negedge clk);
        wr0_en = 1; wr0_addr = 31; wr0_data = 32'h1234;
        @(negedge clk);
        wr0_en = 1; wr0_addr = 30; wr0_data = 32'h77;
        rd_addr = {5'd31, 5'd30}; dbg_addr = 31;
        #2;
        check("pre_reset_dbg_r31", dbg_data, 32'h1234);
        reset = 1'b0;
        #1;
        check("reset_dbg_r31_async", dbg_data, 32'h0);
        check("reset_rd0_bypass_blocked", rd_data[31:0], 32'h0);
        check("reset_rd1_r31", rd_data[63:32], 32'h0);
        @(negedge clk);
        wr0_en = 0;
        reset = 1'b1;
        dbg_addr = 30;
        #2;
        check("post_reset_r30_lost", dbg_data, 32'h0);
        check("post_reset_rd0_r30", rd_data[31:0], 32'h0);
        check("post_reset_busy9", 32'(rd_busy), 32'h0);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
